// File: rtl/bin_to_bcd_seq.sv
// Sequential signed binary to BCD converter (shift-add-3, one bit per clock).
// Emits per-digit codes for 7-segment decoders: 0-9 digits, A minus, F blank.
module bin_to_bcd_seq #(
  parameter int IN_W   = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_W-1:0]       value,
  input  logic                  lz_blank,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [3:0]            sign
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(IN_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    FINISH
  } state_t;

  state_t          st;
  logic            neg;
  logic            lz;
  logic [IN_W-1:0] mag;
  logic [BW-1:0]   acc;
  logic [CW-1:0]   cnt;

  logic [BW-1:0]   adj;
  logic [BW-1:0]   blk;
  logic            lead;

  always_comb begin
    adj = acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5)
        adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
    end
  end

  // Blank zeros from the top down; the ones digit always shows.
  always_comb begin
    blk  = acc;
    lead = lz;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      if (lead && (acc[4*d +: 4] == 4'd0))
        blk[4*d +: 4] = 4'hF;
      else
        lead = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= IDLE;
      neg  <= 1'b0;
      lz   <= 1'b0;
      mag  <= '0;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      bcd  <= '1;
      sign <= 4'hF;
    end else begin
      done <= 1'b0;
      unique case (st)
        IDLE: begin
          if (start) begin
            neg  <= value[IN_W-1];
            mag  <= value[IN_W-1] ? (~value + 1'b1) : value;
            lz   <= lz_blank;
            acc  <= '0;
            cnt  <= CW'(IN_W);
            busy <= 1'b1;
            st   <= CONV;
          end
        end
        CONV: begin
          {acc, mag} <= {adj[BW-2:0], mag, 1'b0};
          cnt        <= cnt - 1'b1;
          if (cnt == CW'(1))
            st <= FINISH;
        end
        FINISH: begin
          bcd  <= blk;
          sign <= neg ? 4'hA : 4'hF;
          done <= 1'b1;
          busy <= 1'b0;
          st   <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: decimal reference model,
// latency, done width, start-while-busy and mid-conversion reset.
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] value;
  logic        lz_blank;
  logic        busy;
  logic        done;
  logic [19:0] bcd;
  logic [3:0]  sign;

  typedef struct {
    logic [19:0] b;
    logic [3:0]  s;
    longint      t0;
  } exp_t;

  exp_t        q[$];
  int          nvec;
  int          nerr;
  longint      cyc;
  logic        prev_done;
  logic [19:0] last_b;

  bin_to_bcd_seq #(.IN_W(16), .DIGITS(5)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .value(value),
    .lz_blank(lz_blank),
    .busy(busy),
    .done(done),
    .bcd(bcd),
    .sign(sign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [19:0] ref_bcd(logic [15:0] v, logic lz);
    int          m;
    logic [19:0] r;
    logic        lead;
    m = $signed(v);
    if (m < 0) m = -m;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    lead = lz;
    for (int i = 4; i >= 1; i--) begin
      if (lead && r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'hF;
      else lead = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [3:0] ref_sign(logic [15:0] v);
    return v[15] ? 4'hA : 4'hF;
  endfunction

  task automatic push(logic [15:0] v, logic lz, longint t0);
    exp_t e;
    e.b  = ref_bcd(v, lz);
    e.s  = ref_sign(v);
    e.t0 = t0;
    q.push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", 1, 0);
  endtask

  task automatic go(logic [15:0] v, logic lz);
    wait_idle();
    start    = 1'b1;
    value    = v;
    lz_blank = lz;
    push(v, lz, cyc + 1);
    @(posedge clk);
    #1;
    chk("busy_after_start", busy, 1);
    start = 1'b0;
    value = $urandom;
    @(negedge clk);
  endtask

  // Output monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        chk("done_width", prev_done, 0);
        if (q.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("bcd", bcd, e.b);
          chk("sign", sign, e.s);
          chk("latency", 32'(cyc - e.t0), 17);
          chk("busy_at_done", busy, 0);
          last_b = e.b;
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  initial begin
    logic [15:0] v;
    int n;
    nvec      = 0;
    nerr      = 0;
    prev_done = 1'b0;
    last_b    = '1;
    rst       = 1'b1;
    start     = 1'b0;
    value     = '0;
    lz_blank  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_bcd", bcd, 20'hFFFFF);
    chk("rst_sign", sign, 4'hF);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    go(16'd0, 1'b1);
    go(16'd1234, 1'b1);
    go(16'd1234, 1'b0);
    go(16'hFFF9, 1'b1);
    go(16'h8000, 1'b1);
    go(16'h7FFF, 1'b1);
    go(16'd100, 1'b1);
    go(16'hFFFF, 1'b0);
    wait_idle();
    repeat (2) @(negedge clk);

    // Start held high: one acceptance every 18 cycles.
    start    = 1'b1;
    value    = 16'd4321;
    lz_blank = 1'b1;
    for (int k = 0; k < 3; k++) push(value, 1'b1, cyc + 1 + 18 * k);
    repeat (37) @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    // Start pulse mid-conversion is ignored; outputs hold.
    go(16'd1234, 1'b0);
    wait_idle();
    @(negedge clk);
    go(16'd555, 1'b1);
    repeat (3) @(negedge clk);
    start = 1'b1;
    value = 16'd9;
    @(negedge clk);
    start = 1'b0;
    chk("hold_bcd", bcd, last_b);
    chk("hold_sign", sign, 4'hF);
    chk("busy_mid", busy, 1);
    wait_idle();
    repeat (3) @(negedge clk);

    // Reset during iteration 8 aborts with no done.
    go(16'd9999, 1'b1);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    q.delete();
    #1;
    chk("abort_bcd", bcd, 20'hFFFFF);
    chk("abort_sign", sign, 4'hF);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    go(16'd42, 1'b1);

    // Random sweep against the decimal model.
    for (int i = 0; i < 250; i++) begin
      v = 16'($urandom);
      go(v, 1'($urandom));
    end

    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
